// File: rtl/harvard_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// harvard_mem_arbiter_if
//   Bundles the CPU-side and memory-side signals of the Harvard memory
//   arbiter: the CPU instruction and data ports, and one shared single-port,
//   waitrequest-style memory.
//
//   modport master : the arbiter's view. It drives the memory request and
//                    the data returned to the CPU.
//   modport slave  : the CPU/memory view. This is the opposite direction of
//                    every signal.
//
//   Signals (widths follow ADDR_W / DATA_W):
//     cpu_active, cpu_clk_enable, cpu_instr_address, cpu_instr_readdata,
//     cpu_data_address, cpu_data_read, cpu_data_write, cpu_data_writedata,
//     cpu_data_readdata, mem_address, mem_read, mem_write, mem_writedata,
//     mem_readdata, mem_waitrequest
// ---------------------------------------------------------------------------
interface harvard_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_active;
    logic              cpu_clk_enable;
    logic [ADDR_W-1:0] cpu_instr_address;
    logic [DATA_W-1:0] cpu_instr_readdata;
    logic [ADDR_W-1:0] cpu_data_address;
    logic              cpu_data_read;
    logic              cpu_data_write;
    logic [DATA_W-1:0] cpu_data_writedata;
    logic [DATA_W-1:0] cpu_data_readdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_waitrequest;

    modport master (
        input  cpu_active, cpu_instr_address, cpu_data_address, cpu_data_read,
               cpu_data_write, cpu_data_writedata, mem_readdata, mem_waitrequest,
        output cpu_clk_enable, cpu_instr_readdata, cpu_data_readdata,
               mem_address, mem_read, mem_write, mem_writedata
    );

    modport slave (
        output cpu_active, cpu_instr_address, cpu_data_address, cpu_data_read,
               cpu_data_write, cpu_data_writedata, mem_readdata, mem_waitrequest,
        input  cpu_clk_enable, cpu_instr_readdata, cpu_data_readdata,
               mem_address, mem_read, mem_write, mem_writedata
    );
endinterface

// File: rtl/harvard_mem_arbiter.sv
// ---------------------------------------------------------------------------
// harvard_mem_arbiter
//   Lets the instruction port and the data port of a Harvard MIPS CPU share
//   one single-port, waitrequest-style memory. Each CPU step runs in this
//   order:
//     FETCH -> DECODE -> [DATA] -> COMMIT
//   COMMIT drives cpu_clk_enable high for one cycle. Fetched words and loaded
//   words are latched, so they stay stable while the CPU is stalled.
//
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous reset, active low
//     bus          harvard_mem_arbiter_if.master (CPU and memory signals)
//     timeout_err  sticky flag: an access waited TIMEOUT_CYCLES cycles
//
//   Build option ARB_TIMEOUT_EN:
//     Defined   : a per-access wait counter abandons an access that has been
//                 stalled for TIMEOUT_CYCLES cycles. The arbiter then parks
//                 in HALT.
//     Undefined : there is no counter, timeout_err is 0, and an access waits
//                 forever.
// ---------------------------------------------------------------------------
module harvard_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    harvard_mem_arbiter_if.master  bus,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_DATA, S_COMMIT, S_HALT
    } state_t;

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_instr, r_rdata;
    logic              w_instr_ld, w_rdata_ld;
    logic              w_mem_read, w_mem_write, w_clk_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_waiting;

    assign w_waiting = (r_state == S_FETCH || r_state == S_DATA) && bus.mem_waitrequest;

    // The counter fires on the last allowed wait cycle. That cycle is the
    // TIMEOUT_CYCLES-th stalled cycle, and the FSM leaves for HALT at the
    // following edge.
    assign w_timeout = w_waiting && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_timeout)
                r_err <= 1'b1;
            // A state change starts a new access, so the count restarts at 0.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_waiting)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign timeout_err = r_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Memory strobes are decoded from the state, so they drop at once
    // (asynchronously) when reset forces the state back to IDLE.
    always_comb begin
        w_next      = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_clk_en    = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_instr_ld  = 1'b0;
        w_rdata_ld  = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_addr     = bus.cpu_instr_address;
                if (!bus.mem_waitrequest) begin
                    w_instr_ld = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            // DECODE is one settle cycle. It lets the CPU decode the new
            // instruction before its data strobes are sampled.
            S_DECODE: w_next = (bus.cpu_data_read || bus.cpu_data_write) ? S_DATA : S_COMMIT;
            S_DATA: begin
                w_addr = bus.cpu_data_address;
                // If read and write are both set, the write wins and the
                // read is not issued.
                if (bus.cpu_data_write) begin
                    w_mem_write = 1'b1;
                    w_wdata     = bus.cpu_data_writedata;
                end else if (bus.cpu_data_read) begin
                    w_mem_read = 1'b1;
                end
                if (!bus.mem_waitrequest) begin
                    w_rdata_ld = bus.cpu_data_read && !bus.cpu_data_write;
                    w_next     = S_COMMIT;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_COMMIT: begin
                w_clk_en = 1'b1;
                w_next   = bus.cpu_active ? S_FETCH : S_HALT;
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= '0;
            r_rdata <= '0;
        end else begin
            if (w_instr_ld) r_instr <= bus.mem_readdata;
            if (w_rdata_ld) r_rdata <= bus.mem_readdata;
        end
    end

    assign bus.cpu_clk_enable     = w_clk_en;
    assign bus.cpu_instr_readdata = r_instr;
    assign bus.cpu_data_readdata  = r_rdata;
    assign bus.mem_address        = w_addr;
    assign bus.mem_read           = w_mem_read;
    assign bus.mem_write          = w_mem_write;
    assign bus.mem_writedata      = w_wdata;

endmodule
